// File: rtl/formacao_pkg.sv
// Shared definitions for the enemy formation controller: game state
// encodings, screen bounds, enemy dimensions and the tick-period helper.
package formacao_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    CLEAR    = 2'd2,
    GAMEOVER = 2'd3
  } estado_t;

  // Screen bounds in pixels.
  localparam int unsigned X_MIN    = 8;    // leftmost legal enemy x
  localparam int unsigned X_MAX    = 631;  // rightmost legal enemy right edge
  localparam int unsigned Y_LIMITE = 440;  // invasion line

  // Enemy sprite dimensions in pixels.
  localparam int unsigned LARGURA = 33;
  localparam int unsigned ALTURA  = 24;

  // Movement tick period: shrinks by passo for every dead enemy and never
  // drops below piso. The comparison is done before the subtraction so the
  // result cannot wrap around.
  function automatic logic [31:0] calc_periodo(input logic [31:0] base,
                                               input logic [31:0] passo,
                                               input logic [31:0] piso,
                                               input logic [31:0] mortos);
    logic [31:0] reducao;
    reducao = passo * mortos;
    if ((base <= piso) || (reducao >= (base - piso))) begin
      return piso;
    end
    return base - reducao;
  endfunction

endpackage

// File: rtl/formacao_ctrl_if.sv
// Bus between the formation controller, the game top level and the array of
// enemy instances. The master view belongs to the controller; the slave view
// belongs to whoever drives enemy state and game controls.
interface formacao_ctrl_if #(
  parameter int unsigned N_INIMIGOS = 8
);

  // Game controls
  logic                       pausa;
  logic                       iniciar;

  // Enemy state, enemy i packed at [10*i+9:10*i]
  logic [10*N_INIMIGOS-1:0]   x_inimigos;
  logic [10*N_INIMIGOS-1:0]   y_inimigos;
  logic [N_INIMIGOS-1:0]      vivo;
  logic [N_INIMIGOS-1:0]      bola_livre;

  // Controller outputs
  logic                       tick_mv;
  logic                       sentidoX;
  logic [N_INIMIGOS-1:0]      disparo;
  logic                       reiniciar;
  logic [1:0]                 estado;
  logic [4:0]                 n_vivos;

  modport master (
    input  pausa, iniciar, x_inimigos, y_inimigos, vivo, bola_livre,
    output tick_mv, sentidoX, disparo, reiniciar, estado, n_vivos
  );

  modport slave (
    output pausa, iniciar, x_inimigos, y_inimigos, vivo, bola_livre,
    input  tick_mv, sentidoX, disparo, reiniciar, estado, n_vivos
  );

endinterface

// File: rtl/formacao_ctrl_arbitro_rr.sv
// arbitro_rr: N-way rotating-priority arbiter. Scans req from index 'inicio'
// upward with wrap-around and grants the first requester found. Purely
// combinational so the caller decides when a grant is taken.
module arbitro_rr #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] inicio,
  output logic [N-1:0]         grant,
  output logic                 valid,
  output logic [$clog2(N)-1:0] indice
);

  localparam int IW = $clog2(N);

  // First requester at or after 'inicio', wrapping past N-1 back to 0.
  always_comb begin
    int j;
    // NOTE: every output gets a value before the loop; a path that leaves one
    // unassigned would infer a latch instead of combinational logic.
    grant  = '0;
    valid  = 1'b0;
    indice = '0;
    for (int k = 0; k < int'(N); k++) begin
      j = int'(inicio) + k;
      if (j >= int'(N)) begin
        j = j - int'(N);
      end
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        indice   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/formacao_ctrl.sv
// formacao_ctrl: sequencing controller for a formation of enemies. Generates
// the movement tick, owns the shared horizontal direction, schedules enemy
// fire and tracks wave-clear / invasion.
// Build option: define DISPARO_ALEATORIO_EN to start the fire scan from a
// 16-bit Galois LFSR instead of the round-robin pointer.
module formacao_ctrl
  import formacao_pkg::*;
#(
  parameter int unsigned N_INIMIGOS = 8,
  parameter int unsigned PASSO      = 2,
  parameter int unsigned DIV_BASE   = 2_000_000,
  parameter int unsigned DIV_STEP   = 200_000,
  parameter int unsigned DIV_MIN    = 250_000,
  parameter int unsigned COOLDOWN   = 25_000_000
) (
  input logic             CLOCK_50,
  input logic             reset,
  formacao_ctrl_if.master bus
);

  localparam int IW = $clog2(N_INIMIGOS);

  estado_t                estado_q;
  logic                   sentido_q;
  logic                   tick_q;
  logic                   reiniciar_q;
  logic [N_INIMIGOS-1:0]  disparo_q;
  logic [31:0]            div_cnt_q;
  logic [31:0]            cooldown_q;

  logic [31:0]            periodo;
  logic [4:0]             n_vivos;
  logic                   bate_dir;
  logic                   bate_esq;
  logic                   invasao;
  logic                   run_ativo;

  logic [N_INIMIGOS-1:0]  req;
  logic [N_INIMIGOS-1:0]  arb_grant;
  logic                   arb_valid;
  logic [IW-1:0]          arb_indice;
  logic [IW-1:0]          inicio_scan;

  // Count of alive enemies; also sets how fast the formation moves.
  always_comb begin
    n_vivos = '0;
    for (int i = 0; i < int'(N_INIMIGOS); i++) begin
      n_vivos = n_vivos + 5'(bus.vivo[i]);
    end
  end

  assign periodo = calc_periodo(32'(DIV_BASE), 32'(DIV_STEP), 32'(DIV_MIN),
                                32'(N_INIMIGOS) - 32'(n_vivos));

  // Edge and invasion detection over alive enemies only; 12-bit sums so the
  // right-edge and bottom-edge additions cannot overflow.
  always_comb begin
    bate_dir = 1'b0;
    bate_esq = 1'b0;
    invasao  = 1'b0;
    for (int i = 0; i < int'(N_INIMIGOS); i++) begin
      if (bus.vivo[i]) begin
        if ({2'b00, bus.x_inimigos[10*i +: 10]} + 12'(LARGURA + PASSO) > 12'(X_MAX)) begin
          bate_dir = 1'b1;
        end
        if ({2'b00, bus.x_inimigos[10*i +: 10]} < 12'(X_MIN + PASSO)) begin
          bate_esq = 1'b1;
        end
        if ({2'b00, bus.y_inimigos[10*i +: 10]} + 12'(ALTURA) >= 12'(Y_LIMITE)) begin
          invasao = 1'b1;
        end
      end
    end
  end

  // Divider, cooldown and scan pointer only advance in a RUN cycle that is
  // not paused and is not about to leave RUN, so no tick or grant is ever
  // emitted while estado shows CLEAR or GAMEOVER.
  assign run_ativo = (estado_q == RUN) && !bus.pausa && (n_vivos != 5'd0) && !invasao;

  assign req = bus.vivo & bus.bola_livre;

  arbitro_rr #(
    .N (N_INIMIGOS)
  ) u_arbitro (
    .req    (req),
    .inicio (inicio_scan),
    .grant  (arb_grant),
    .valid  (arb_valid),
    .indice (arb_indice)
  );

`ifdef DISPARO_ALEATORIO_EN
  logic [15:0] lfsr_q;

  // Free-running Galois LFSR, taps 16,14,13,11; picks a random scan start.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign inicio_scan = IW'(lfsr_q % 16'(N_INIMIGOS));
`else
  logic [IW-1:0] ptr_q;

  // Round-robin pointer: moves just past the enemy that was granted.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (run_ativo && (cooldown_q == 32'd0) && arb_valid) begin
      ptr_q <= (arb_indice == IW'(N_INIMIGOS - 1)) ? '0 : arb_indice + IW'(1);
    end
  end

  assign inicio_scan = ptr_q;
`endif

  // Game FSM with registered outputs: restart, movement tick, direction and
  // fire grants.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      estado_q    <= IDLE;
      sentido_q   <= 1'b1;
      tick_q      <= 1'b0;
      reiniciar_q <= 1'b0;
      disparo_q   <= '0;
      div_cnt_q   <= '0;
      cooldown_q  <= 32'(COOLDOWN);
    end else begin
      // NOTE: state is updated with <= so every right-hand side below sees
      // the pre-edge values, exactly as the flip-flops do in hardware.
      tick_q      <= 1'b0;
      reiniciar_q <= 1'b0;
      disparo_q   <= '0;

      case (estado_q)
        RUN: begin
          if (n_vivos == 5'd0) begin
            estado_q <= CLEAR;
          end else if (invasao) begin
            estado_q <= GAMEOVER;
          end

          // Direction is decided in the tick cycle itself, so the new value
          // is on sentidoX from the following cycle.
          if (tick_q) begin
            if (sentido_q && bate_dir) begin
              sentido_q <= 1'b0;
            end else if (!sentido_q && bate_esq) begin
              sentido_q <= 1'b1;
            end
          end

          if (run_ativo) begin
            // '>=' also wraps a count left stale by a shorter new period.
            if (div_cnt_q >= periodo - 32'd1) begin
              div_cnt_q <= '0;
              tick_q    <= 1'b1;
            end else begin
              div_cnt_q <= div_cnt_q + 32'd1;
            end

            if (cooldown_q != 32'd0) begin
              cooldown_q <= cooldown_q - 32'd1;
            end else if (arb_valid) begin
              disparo_q  <= arb_grant;
              cooldown_q <= 32'(COOLDOWN);
            end
          end
        end

        default: begin
          // IDLE, CLEAR and GAMEOVER all restart the same way.
          if (bus.iniciar) begin
            estado_q    <= RUN;
            reiniciar_q <= 1'b1;
            sentido_q   <= 1'b1;
            div_cnt_q   <= '0;
            cooldown_q  <= 32'(COOLDOWN);
          end
        end
      endcase
    end
  end

  assign bus.tick_mv   = tick_q;
  assign bus.sentidoX  = sentido_q;
  assign bus.disparo   = disparo_q;
  assign bus.reiniciar = reiniciar_q;
  assign bus.estado    = estado_q;
  assign bus.n_vivos   = n_vivos;

endmodule

// File: tb/tb_formacao_ctrl.sv
// Self-checking bench for formacao_ctrl with short periods (DIV_BASE=10,
// DIV_STEP=2, DIV_MIN=5, COOLDOWN=4). Period table in a loop, hand-written
// sequences for direction, FSM, pause and reset, and a grant scoreboard.
module tb_formacao_ctrl;
  import formacao_pkg::*;

  localparam int N = 8;

  typedef struct {
    logic [7:0] vivo;
    logic [4:0] n_exp;
    int         p_exp;
  } vetor_t;

  typedef struct {
    logic [7:0] grant;
    int         gap;   // expected cycles since previous grant, -1 = skip
  } sb_item_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_grant_cyc = 0;
  int n_grants = 0;
  bit sb_en = 1'b0;
  sb_item_t sb_q[$];
  sb_item_t sb_e;
  vetor_t tabela[6];

  formacao_ctrl_if #(.N_INIMIGOS(N)) bus ();

  formacao_ctrl #(
    .N_INIMIGOS (N),
    .PASSO      (2),
    .DIV_BASE   (10),
    .DIV_STEP   (2),
    .DIV_MIN    (5),
    .COOLDOWN   (4)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic set_x(input int i, input int v);
    bus.x_inimigos[10*i +: 10] = 10'(v);
  endtask

  task automatic set_y(input int i, input int v);
    bus.y_inimigos[10*i +: 10] = 10'(v);
  endtask

  // Returns the number of negedges until tick_mv is seen high (0 = none).
  task automatic wait_tick(input string nome, output int k);
    k = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (bus.tick_mv) begin
        k = c;
        break;
      end
    end
    check({nome, "_tick_seen"}, 32'(k != 0), 32'd1);
  endtask

  // Waits, bounded, until the scoreboard has consumed every expected grant.
  task automatic wait_sb(input string nome);
    for (int c = 0; c < 100; c++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check({nome, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic push(input logic [7:0] g, input int gap);
    sb_e.grant = g;
    sb_e.gap   = gap;
    sb_q.push_back(sb_e);
  endtask

  // Scoreboard monitor: every fire pulse must match the next expected grant.
  always @(negedge clk) begin
    sb_item_t e;
    if (sb_en && (bus.disparo != '0)) begin
      n_grants++;
      if (sb_q.size() == 0) begin
        check("grant_unexpected", 32'(bus.disparo), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("grant_onehot", 32'(bus.disparo), 32'(e.grant));
        if (e.gap >= 0) check("grant_gap", 32'(cyc - last_grant_cyc), 32'(e.gap));
      end
      last_grant_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;

    tabela[0] = '{8'hFF, 5'd8, 10};
    tabela[1] = '{8'hFE, 5'd7, 8};
    tabela[2] = '{8'hFC, 5'd6, 6};
    tabela[3] = '{8'hF8, 5'd5, 5};   // 10-6=4, floored to 5
    tabela[4] = '{8'h0F, 5'd4, 5};
    tabela[5] = '{8'h81, 5'd2, 5};

    rst_n          = 1'b0;
    bus.pausa      = 1'b0;
    bus.iniciar    = 1'b0;
    bus.vivo       = 8'hFF;
    bus.bola_livre = 8'hFF;
    for (int i = 0; i < N; i++) begin
      set_x(i, 100);
      set_y(i, 50);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_estado", 32'(bus.estado), 32'(IDLE));
    check("rst_sentido", 32'(bus.sentidoX), 32'd1);
    check("rst_tick", 32'(bus.tick_mv), 32'd0);
    check("rst_disparo", 32'(bus.disparo), 32'd0);
    check("rst_reiniciar", 32'(bus.reiniciar), 32'd0);
    check("rst_n_vivos", 32'(bus.n_vivos), 32'd8);
    rst_n = 1'b1;

    // IDLE stays quiet
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.tick_mv || (bus.disparo != '0)) cnt++;
    end
    check("idle_quiet", 32'(cnt), 32'd0);
    check("idle_estado", 32'(bus.estado), 32'(IDLE));

    // Start; iniciar held a second cycle must be ignored in RUN
    bus.iniciar = 1'b1;
    @(negedge clk);
    check("start_reiniciar", 32'(bus.reiniciar), 32'd1);
    check("start_estado", 32'(bus.estado), 32'(RUN));
    @(negedge clk);
    check("reiniciar_one_cycle", 32'(bus.reiniciar), 32'd0);
    check("run_ignores_iniciar", 32'(bus.estado), 32'(RUN));
    bus.iniciar = 1'b0;

    // Period table
    foreach (tabela[i]) begin
      bus.vivo = tabela[i].vivo;
      #1;
      check($sformatf("n_vivos_%0d", i), 32'(bus.n_vivos), 32'(tabela[i].n_exp));
      wait_tick("sync", k);
      wait_tick("period", k);
      check($sformatf("period_%0d", i), 32'(k), 32'(tabela[i].p_exp));
    end
    bus.vivo = 8'hFF;
    @(negedge clk);

    // Right edge flip, single flip per tick
    set_x(3, 598);
    wait_tick("dir_a", k);
    check("dir_before_flip", 32'(bus.sentidoX), 32'd1);
    @(negedge clk);
    check("dir_flip_right", 32'(bus.sentidoX), 32'd0);
    wait_tick("dir_b", k);
    @(negedge clk);
    check("dir_single_flip", 32'(bus.sentidoX), 32'd0);

    // Left edge: x=10 is legal, x=9 flips
    set_x(3, 100);
    set_x(6, 10);
    wait_tick("dir_c", k);
    @(negedge clk);
    check("dir_left_boundary", 32'(bus.sentidoX), 32'd0);
    set_x(6, 9);
    wait_tick("dir_d", k);
    @(negedge clk);
    check("dir_flip_left", 32'(bus.sentidoX), 32'd1);
    set_x(6, 100);

    // Wave clear
    bus.vivo = 8'h00;
    @(negedge clk);
    check("clear_estado", 32'(bus.estado), 32'(CLEAR));
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.tick_mv || (bus.disparo != '0)) cnt++;
    end
    check("clear_quiet", 32'(cnt), 32'd0);

    // Restart from CLEAR; dead enemy at the right edge must not flip
    set_x(3, 598);
    bus.vivo    = 8'hF7;
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    check("restart_clear_estado", 32'(bus.estado), 32'(RUN));
    check("restart_clear_reiniciar", 32'(bus.reiniciar), 32'd1);
    wait_tick("dead", k);
    @(negedge clk);
    check("dir_dead_ignored", 32'(bus.sentidoX), 32'd1);

    // Invasion line: 415 safe, dead enemy below line ignored, 416 ends game
    set_y(4, 450);
    set_y(2, 415);
    bus.vivo = 8'hE7;
    @(negedge clk);
    check("inv_boundary", 32'(bus.estado), 32'(RUN));
    set_y(2, 416);
    @(negedge clk);
    check("inv_gameover", 32'(bus.estado), 32'(GAMEOVER));

    // Restart from GAMEOVER
    set_y(2, 50);
    set_y(4, 50);
    set_x(3, 100);
    bus.vivo    = 8'hFF;
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    check("restart_go_estado", 32'(bus.estado), 32'(RUN));

    // Pause three cycles into a period; divider must resume from count 3
    wait_tick("pause_sync", k);
    repeat (3) @(negedge clk);
    bus.pausa = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tick_mv || (bus.disparo != '0)) cnt++;
    end
    check("pause_quiet", 32'(cnt), 32'd0);
    check("pause_estado", 32'(bus.estado), 32'(RUN));
    bus.pausa = 1'b0;
    wait_tick("pause_resume", k);
    check("pause_resume_cycles", 32'(k), 32'd7);

    // Asynchronous reset, checked between clock edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_estado", 32'(bus.estado), 32'(IDLE));
    check("async_rst_sentido", 32'(bus.sentidoX), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fire A: all eligible, 0,1,2,3 every 5 cycles
    push(8'h01, -1);
    push(8'h02, 5);
    push(8'h04, 5);
    push(8'h08, 5);
    sb_en = 1'b1;
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    wait_sb("fire_a");

    // Fire B: enemy 1 not eligible, expect 0,2,3 from a fresh pointer
    sb_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.bola_livre = 8'hFD;
    push(8'h01, -1);
    push(8'h04, 5);
    push(8'h08, 5);
    sb_en = 1'b1;
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    wait_sb("fire_b");

    // Nobody eligible, then enemy 5 becomes eligible: grant next cycle
    bus.bola_livre = 8'h00;
    cnt = n_grants;
    repeat (12) @(negedge clk);
    check("no_eligible", 32'(n_grants - cnt), 32'd0);
    bus.bola_livre = 8'h20;
    push(8'h20, -1);
    @(negedge clk);
    check("grant_latency", 32'(bus.disparo), 32'h20);
    #1;
    wait_sb("fire_c");
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/formacao_ctrl.md
Name: formacao_ctrl

Overview:
Sequencing controller for a formation of N enemy instances. It generates the enemy movement tick that drives their CLOCK_MV inputs, and owns the shared horizontal direction (sentidoX), flipping it when the formation hits a screen edge. It also schedules which enemy fires next and tracks wave-clear and invasion. It sits between the game top level and the array of enemy instances.

Parameters:
N_INIMIGOS, 8, number of enemies controlled (2..16)
X_MIN, 8, leftmost legal enemy x
X_MAX, 631, rightmost legal enemy right edge (x + LARGURA)
LARGURA, 33, enemy width in pixels
ALTURA, 24, enemy height in pixels
PASSO, 2, horizontal pixels moved per tick
Y_LIMITE, 440, invasion line; alive enemy with y + ALTURA >= Y_LIMITE ends the game
DIV_BASE, 2_000_000, tick period in CLOCK_50 cycles with all enemies alive
DIV_STEP, 200_000, period reduction per dead enemy
DIV_MIN, 250_000, period floor
COOLDOWN, 25_000_000, CLOCK_50 cycles between shots

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
pausa  in  1  freeze everything while high
iniciar  in  1  start/restart request, level, sampled per cycle
x_inimigos  in  10*N_INIMIGOS  packed enemy x; enemy i at [10*i+9:10*i]
y_inimigos  in  10*N_INIMIGOS  packed enemy y, same packing
vivo  in  N_INIMIGOS  alive flags
bola_livre  in  N_INIMIGOS  enemy i's projectile is idle and may be fired
tick_mv  out  1  movement tick, drives enemy CLOCK_MV
sentidoX  out  1  1 = right, 0 = left
disparo  out  N_INIMIGOS  one-hot fire grant, 1-cycle pulse
reiniciar  out  1  1-cycle restart pulse to enemies (reiniciarJogo)
estado  out  2  0 IDLE, 1 RUN, 2 CLEAR, 3 GAMEOVER
n_vivos  out  5  popcount of vivo, combinational

Behaviour:
- Reset values: estado=IDLE, sentidoX=1, tick_mv=0, disparo=0, reiniciar=0, divider=0, cooldown=COOLDOWN, rr pointer=0.
- FSM transitions:
  - IDLE: iniciar=1 -> pulse reiniciar, go to RUN, reload divider and cooldown, sentidoX=1.
  - RUN: if n_vivos==0 -> CLEAR. Else if any alive enemy has y+ALTURA >= Y_LIMITE -> GAMEOVER. These two are mutually exclusive.
  - CLEAR or GAMEOVER: iniciar=1 -> same restart actions as IDLE -> RUN.
- Tick period P = max(DIV_MIN, DIV_BASE - DIV_STEP*(N_INIMIGOS - n_vivos)), computed in 32 bits and saturating at DIV_MIN (no underflow).
- Divider counts 0..P-1. tick_mv is high for exactly one cycle when the count reaches P-1, then the count returns to 0. A change of P mid-count takes effect at the next compare, and a count already >= P wraps immediately.
- Direction:
  - Evaluated only in the tick cycle.
  - If sentidoX=1 and any alive enemy satisfies x+LARGURA+PASSO > X_MAX, sentidoX <= 0.
  - If sentidoX=0 and any alive enemy satisfies x < X_MIN+PASSO, sentidoX <= 1.
  - The new value is visible from the cycle after the tick, before the enemies' falling-edge sample.
  - Dead enemies are ignored. At most one flip per tick.
- Fire scheduling:
  - cooldown decrements each RUN cycle while above 0.
  - At 0, grant the first index i, scanning from rr pointer upward with wrap, where vivo[i] & bola_livre[i].
  - On a grant: disparo = one-hot(i) for 1 cycle, pointer <= (i+1) mod N, cooldown <= COOLDOWN.
  - With no eligible enemy, cooldown holds at 0 and the scan retries every cycle.
- pausa=1 in RUN: divider, cooldown and pointer freeze; tick_mv=0, disparo=0. FSM checks still run.
- Outside RUN: tick_mv=0, disparo=0.
- iniciar while in RUN is ignored.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

Optional Feature:
DISPARO_ALEATORIO_EN:
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset), clocked every cycle, replaces the rr pointer as scan start (lfsr mod N_INIMIGOS). The pointer update on a grant is not used.
- Undefined: round-robin as above, and the LFSR is not synthesized.

Decomposition:
- Shared package formacao_pkg holds:
  - estado encodings (IDLE/RUN/CLEAR/GAMEOVER)
  - screen bounds X_MIN, X_MAX, Y_LIMITE
  - enemy dimensions LARGURA, ALTURA
- One sub-module, arbitro_rr: parameterised N-way rotating-priority arbiter. Inputs req and start pointer; outputs one-hot grant, valid and index. It is reused by the player-side logic.

Test Plan:
- Reset low then high with all 8 alive; DIV_BASE=10 -> tick_mv pulses every 10 cycles, sentidoX=1, estado=IDLE until iniciar; iniciar -> reiniciar pulses 1 cycle, estado=RUN.
- Enemy 3 at x=598 (598+33+2=633 > 631), sentidoX=1 -> sentidoX=0 the cycle after the next tick, with no further flip on the following tick. Same position with vivo[3]=0 -> no flip.
- Kill 3 enemies with DIV_BASE=10, DIV_STEP=2, DIV_MIN=5 -> period becomes 5 (floored, not 4).
- COOLDOWN=4, all eligible -> grants 0,1,2,... every 5 cycles; bola_livre[1]=0 -> sequence 0,2,3. No eligible enemy -> no grant; a grant follows in the cycle after the first one becomes eligible.
- vivo goes to 0 -> estado=CLEAR next cycle. Alive enemy at y=416 (416+24=440) -> GAMEOVER. pausa=1 for 20 cycles -> no tick or disparo, and the divider resumes from its frozen count.
